mem_bus_arbiter: RTL and testbench

- Shares one byte-serial main-memory port between two cache_controller instances (requester 0 = I-cache, requester 1 = D-cache).
- Each granted request is a fixed burst of BLOCK_SIZE beats: a line fill (read) or a write-back (write).
- Round-robin arbitration; the grant is held for the whole burst. Per-requester grant counters are provided for performance stats.

---
 rtl/mem_bus_arbiter_if.sv | 46 ++++
 rtl/mem_bus_arbiter.sv | 115 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - requester, memory and statistics signals of the two-port burst arbiter
// The slave modport is the arbiter; the master modport drives requests and the memory response.
interface mem_bus_arbiter_if #(
  parameter int BLOCK_SIZE = 16,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 8
);
  localparam int OFF_W = $clog2(BLOCK_SIZE);

  logic              req0;
  logic              req1;
  logic              rd_wr0;
  logic              rd_wr1;
  logic [ADDR_W-1:0] add0;
  logic [ADDR_W-1:0] add1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              ack0;
  logic              ack1;
  logic              done0;
  logic              done1;
  logic [DATA_W-1:0] rdata;
  logic [OFF_W-1:0]  beat_cnt;
  logic              mem_valid;
  logic              mem_rd_wr;
  logic [ADDR_W-1:0] mem_add;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [31:0]       total_grants0;
  logic [31:0]       total_grants1;

  modport master (
    output req0, req1, rd_wr0, rd_wr1, add0, add1, wdata0, wdata1, mem_rdata, mem_ready,
    input  gnt0, gnt1, ack0, ack1, done0, done1, rdata, beat_cnt,
    input  mem_valid, mem_rd_wr, mem_add, mem_wdata, total_grants0, total_grants1
  );

  modport slave (
    input  req0, req1, rd_wr0, rd_wr1, add0, add1, wdata0, wdata1, mem_rdata, mem_ready,
    output gnt0, gnt1, ack0, ack1, done0, done1, rdata, beat_cnt,
    output mem_valid, mem_rd_wr, mem_add, mem_wdata, total_grants0, total_grants1
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one byte-serial memory port between two caches
// A grant is held for a fixed BLOCK_SIZE-beat burst, followed by a one-cycle DONE bubble.
module mem_bus_arbiter #(
  parameter int BLOCK_SIZE = 16,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 8,
  localparam int OFF_W     = $clog2(BLOCK_SIZE)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  mem_bus_arbiter_if.slave io_bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_DONE
  } state_t;

  state_t                   r_state;
  logic                     r_ptr;
  logic                     r_sel;
  logic                     r_gnt0;
  logic                     r_gnt1;
  logic                     r_done0;
  logic                     r_done1;
  logic                     r_valid;
  logic                     r_rd_wr;
  logic [OFF_W-1:0]         r_beat;
  logic [ADDR_W-OFF_W-1:0]  r_blk;
  logic [31:0]              r_cnt0;
  logic [31:0]              r_cnt1;

  logic                     w_pick;
  logic                     w_last;
  logic                     w_unused_off;

  // r_ptr=1 favours requester 1 when both ask at once
  assign w_pick       = io_bus.req1 & (~io_bus.req0 | r_ptr);
  assign w_last       = (r_beat == OFF_W'(BLOCK_SIZE - 1));
  assign w_unused_off = ^{io_bus.add0[OFF_W-1:0], io_bus.add1[OFF_W-1:0]};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_ptr   <= 1'b0;
      r_sel   <= 1'b0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_valid <= 1'b0;
      r_rd_wr <= 1'b0;
      r_beat  <= '0;
      r_blk   <= '0;
      r_cnt0  <= '0;
      r_cnt1  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.req0 || io_bus.req1) begin
            r_sel   <= w_pick;
            r_blk   <= w_pick ? io_bus.add1[ADDR_W-1:OFF_W] : io_bus.add0[ADDR_W-1:OFF_W];
            r_rd_wr <= w_pick ? io_bus.rd_wr1 : io_bus.rd_wr0;
            r_gnt0  <= ~w_pick;
            r_gnt1  <= w_pick;
            r_valid <= 1'b1;
            r_beat  <= '0;
            if (w_pick) r_cnt1 <= r_cnt1 + 32'd1;
            else        r_cnt0 <= r_cnt0 + 32'd1;
            r_state <= S_BURST;
          end
        end
        S_BURST: begin
          if (io_bus.mem_ready) begin
            if (w_last) begin
              r_gnt0  <= 1'b0;
              r_gnt1  <= 1'b0;
              r_valid <= 1'b0;
              r_done0 <= ~r_sel;
              r_done1 <= r_sel;
              r_beat  <= '0;
              r_ptr   <= ~r_sel;
              r_state <= S_DONE;
            end else begin
              r_beat <= r_beat + OFF_W'(1);
            end
          end
        end
        S_DONE: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_bus.gnt0          = r_gnt0;
  assign io_bus.gnt1          = r_gnt1;
  assign io_bus.ack0          = r_gnt0 & io_bus.mem_ready;
  assign io_bus.ack1          = r_gnt1 & io_bus.mem_ready;
  assign io_bus.done0         = r_done0;
  assign io_bus.done1         = r_done1;
  assign io_bus.rdata         = io_bus.mem_rdata;
  assign io_bus.beat_cnt      = r_beat;
  assign io_bus.mem_valid     = r_valid;
  assign io_bus.mem_rd_wr     = r_rd_wr;
  assign io_bus.mem_add       = {r_blk, r_beat};
  assign io_bus.mem_wdata     = r_gnt0 ? io_bus.wdata0 : (r_gnt1 ? io_bus.wdata1 : '0);
  assign io_bus.total_grants0 = r_cnt0;
  assign io_bus.total_grants1 = r_cnt1;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard bench for mem_bus_arbiter with a burst-level reference model
// Expected beats and done pulses are queued at issue time; a monitor pops them on ack/done.
module tb_mem_bus_arbiter;
  localparam int BS = 16;
  localparam int AW = 32;
  localparam int DW = 8;

  typedef struct {
    bit          id;
    bit          rd;
    logic [31:0] addr;
    logic [7:0]  data;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.BLOCK_SIZE(BS), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_bus_arbiter #(.BLOCK_SIZE(BS), .ADDR_W(AW), .DATA_W(DW)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .io_bus  (bus)
  );

  beat_t      exp_q[$];
  int         exp_done_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         model_ptr;
  int         model_cnt[2];
  int         valid_cycles;
  int         ready_mode = 0;
  logic [7:0] wseed0 = 8'h00;
  logic [7:0] wseed1 = 8'h00;
  int         hold = 0;
  logic [3:0] last_beat = 4'h0;

  // Memory returns a byte derived from the address; requesters supply seed + beat index.
  always_comb bus.mem_rdata = bus.mem_add[7:0] ^ 8'hA5;
  always_comb bus.wdata0    = wseed0 + 8'(bus.beat_cnt);
  always_comb bus.wdata1    = wseed1 + 8'(bus.beat_cnt);

  always @(posedge clk) begin
    #1;
    if (bus.beat_cnt != last_beat) hold = 0;
    last_beat = bus.beat_cnt;
    case (ready_mode)
      0: bus.mem_ready = 1'b1;
      1: bus.mem_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (bus.mem_valid && (bus.beat_cnt == 4'd3 || bus.beat_cnt == 4'd7) && hold < 2) begin
          bus.mem_ready = 1'b0;
          hold++;
        end else begin
          bus.mem_ready = 1'b1;
        end
      end
    endcase
  end

  task automatic check(string nm, longint got, longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic push_burst(int id, bit rd, logic [31:0] a, logic [7:0] seed);
    beat_t e;
    for (int k = 0; k < BS; k++) begin
      e.id   = id[0];
      e.rd   = rd;
      e.addr = {a[31:4], 4'(k)};
      e.data = rd ? (e.addr[7:0] ^ 8'hA5) : (seed + 8'(k));
      exp_q.push_back(e);
    end
    exp_done_q.push_back(id);
    model_cnt[id]++;
    model_ptr = 1 - id;
  endtask

  task automatic monitor();
    beat_t      e;
    logic [7:0] gd;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_valid) valid_cycles++;
        if (bus.ack0 || bus.ack1) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat_unexpected: ack0=%b ack1=%b addr=%h, required no beat", bus.ack0, bus.ack1, bus.mem_add);
          end else begin
            e  = exp_q.pop_front();
            gd = e.rd ? bus.rdata : bus.mem_wdata;
            if ((bus.ack0 && bus.ack1) || bus.ack1 != e.id || bus.mem_add !== e.addr ||
                bus.mem_rd_wr !== e.rd || gd !== e.data)
              begin
                n_fail++;
                $display("FAIL beat: got ack1=%b addr=%h rd=%b data=%h required id=%0d addr=%h rd=%b data=%h",
                         bus.ack1, bus.mem_add, bus.mem_rd_wr, gd, e.id, e.addr, e.rd, e.data);
              end
          end
        end
        if (bus.done0 || bus.done1) begin
          n_tests++;
          if (exp_done_q.size() == 0) begin
            n_fail++;
            $display("FAIL done_unexpected: done0=%b done1=%b, required none", bus.done0, bus.done1);
          end else begin
            int did;
            did = exp_done_q.pop_front();
            if ((bus.done0 && bus.done1) || int'(bus.done1) != did) begin
              n_fail++;
              $display("FAIL done: got done0=%b done1=%b required requester %0d", bus.done0, bus.done1, did);
            end
          end
        end
      end
    end
  endtask

  task automatic set_req(int id, bit v);
    if (id == 0) bus.req0 = v;
    else         bus.req1 = v;
  endtask

  task automatic wait_done(int id);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if ((id == 0) ? bus.done0 : bus.done1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 0, 1);
    set_req(id, 1'b0);
  endtask

  task automatic run_round(bit u0, bit u1, bit rd0, bit rd1, logic [31:0] a0, logic [31:0] a1,
                           logic [7:0] s0, logic [7:0] s1, int mode, bit drop_early);
    int order[$];
    int first;
    bit ok;
    ready_mode = mode;
    @(negedge clk);
    first = (u0 && u1) ? model_ptr : (u1 ? 1 : 0);
    order.push_back(first);
    if (u0 && u1) order.push_back(1 - first);
    foreach (order[i]) begin
      if (order[i] == 0) push_burst(0, rd0, a0, s0);
      else               push_burst(1, rd1, a1, s1);
    end
    wseed0 = s0;  wseed1 = s1;
    bus.rd_wr0 = rd0;  bus.add0 = a0;  bus.req0 = u0;
    bus.rd_wr1 = rd1;  bus.add1 = a1;  bus.req1 = u1;
    valid_cycles = 0;
    @(negedge clk);
    check("grant_latency", {bus.gnt0, bus.gnt1, bus.mem_valid}, (first == 1) ? 3'b011 : 3'b101);
    check("first_beat", bus.beat_cnt, 0);
    // Address and direction changes after grant must not reach the memory port.
    if (first == 0) begin bus.add0 = ~a0; bus.rd_wr0 = ~rd0; end
    else            begin bus.add1 = ~a1; bus.rd_wr1 = ~rd1; end
    if (drop_early) begin
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        if (bus.beat_cnt == 4'd5) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      check("reach_beat5", ok, 1);
      set_req(first, 1'b0);
    end
    foreach (order[i]) wait_done(order[i]);
    check("total_grants0", bus.total_grants0, model_cnt[0]);
    check("total_grants1", bus.total_grants1, model_cnt[1]);
    if (mode != 1) check("valid_cycles", valid_cycles, ((mode == 0) ? BS : BS + 4) * order.size());
  endtask

  initial begin
    bit ok;
    rst = 1'b1;
    bus.req0 = 0; bus.req1 = 0; bus.rd_wr0 = 0; bus.rd_wr1 = 0; bus.add0 = '0; bus.add1 = '0;
    model_ptr = 0; model_cnt[0] = 0; model_cnt[1] = 0; valid_cycles = 0;
    fork monitor(); join_none
    repeat (3) @(negedge clk);
    check("rst_ctrl", {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.done0, bus.done1, bus.mem_valid, bus.mem_rd_wr}, 0);
    check("rst_mem_add", bus.mem_add, 0);
    check("rst_wdata_beat", {bus.mem_wdata, bus.beat_cnt}, 0);
    check("rst_counters", {bus.total_grants0, bus.total_grants1}, 0);
    rst = 1'b0;

    run_round(1, 0, 1, 0, 32'h111aaaab, 32'h0, 8'h00, 8'h00, 0, 0);
    run_round(0, 1, 0, 0, 32'h0, 32'h222aaaa0, 8'h00, 8'h64, 0, 0);
    run_round(1, 1, 1, 0, 32'h12345670, 32'h89abcde5, 8'h10, 8'h20, 0, 0);
    run_round(1, 1, 0, 1, 32'h0badc0d0, 32'hfeedf00d, 8'h30, 8'h40, 0, 0);
    run_round(1, 0, 1, 0, 32'h44440000, 32'h0, 8'h00, 8'h00, 2, 0);
    run_round(1, 0, 0, 0, 32'h55550010, 32'h0, 8'hc0, 8'h00, 0, 1);

    for (int r = 0; r < 20; r++) begin
      bit [1:0] sel;
      sel = 2'($urandom_range(1, 3));
      run_round(sel[0], sel[1], 1'($urandom), 1'($urandom), $urandom, $urandom,
                8'($urandom), 8'($urandom), $urandom_range(0, 2), 1'($urandom));
    end

    // Reset in the middle of a burst: outputs clear at once and no done pulse follows.
    ready_mode = 0;
    @(negedge clk);
    push_burst(1, 1, 32'h333aaaa0, 8'h00);
    bus.rd_wr1 = 1; bus.add1 = 32'h333aaaa0; bus.req1 = 1;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.beat_cnt == 4'd8) begin ok = 1'b1; break; end
    end
    check("reach_beat8", ok, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_ctrl", {bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.done0, bus.done1, bus.mem_valid, bus.mem_rd_wr}, 0);
    check("arst_mem_add", bus.mem_add, 0);
    check("arst_wdata_beat", {bus.mem_wdata, bus.beat_cnt}, 0);
    check("arst_counters", {bus.total_grants0, bus.total_grants1}, 0);
    exp_q.delete();
    exp_done_q.delete();
    model_cnt[0] = 0; model_cnt[1] = 0; model_ptr = 0;
    bus.req1 = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("no_done_after_rst", {bus.done0, bus.done1}, 0);
    run_round(0, 1, 1, 1, 32'h0, 32'h777aaaa0, 8'h00, 8'h00, 0, 0);

    repeat (3) @(negedge clk);
    check("sb_beats_left", exp_q.size(), 0);
    check("sb_done_left", exp_done_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
